// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array controller: FSM states, PE mode
// encodings and the wavefront flush length.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } sa_ctrl_state_t;

    localparam logic [1:0] SA_MODE_MAC    = 2'd0;
    localparam logic [1:0] SA_MODE_MAX    = 2'd1;
    localparam logic [1:0] SA_MODE_BYPASS = 2'd2;
    localparam logic [1:0] SA_MODE_RSVD   = 2'd3;

    // Cycles needed for the last operand to travel from PE[0][0] to PE[H-1][W-1].
    function automatic int sa_flush_len(input int w, input int h);
        return w + h - 2;
    endfunction

endpackage

// File: rtl/sa_skew_buffer.sv
// Diagonal skew buffer: lane l is delayed by l enabled cycles; lane 0 passes
// straight through. The shift registers advance only while i_en is high.
module sa_skew_buffer #(
    parameter int LANES = 2,
    parameter int WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic [LANES-1:0][WIDTH-1:0] i_data,
    output logic [LANES-1:0][WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] lane_out [LANES];

    assign lane_out[0] = i_data[0];

    for (genvar l = 1; l < LANES; l++) begin : g_lane
        logic [l-1:0][WIDTH-1:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d = pipe_q;
            if (i_en) begin
                pipe_d[0] = i_data[l];
                for (int s = 1; s < l; s++) begin
                    pipe_d[s] = pipe_q[s-1];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign lane_out[l] = pipe_q[l-1];
    end

    always_comb begin
        o_data = '0;
        for (int l = 0; l < LANES; l++) begin
            o_data[l] = lane_out[l];
        end
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for the output-stationary systolic array: CLEAR, FEED, FLUSH,
// DRAIN, DONE. Define SA_CTRL_SKEW_EN to apply the operand skew internally.
module systolic_array_ctrl
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int S_WIDTH    = 2,
    parameter int S_HEIGHT   = 2,
    parameter int K_WIDTH    = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [K_WIDTH-1:0]                  i_k_len,
    input  logic [1:0]                          i_mode,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    input  logic [S_HEIGHT-1:0][DATA_WIDTH-1:0] i_ifmap,
    input  logic [S_WIDTH-1:0][DATA_WIDTH-1:0]  i_weight,
    output logic [S_HEIGHT-1:0][DATA_WIDTH-1:0] o_ifmap,
    output logic [S_WIDTH-1:0][DATA_WIDTH-1:0]  o_weight,
    output logic [1:0]                          o_mode,
    output logic                                o_reg_clear,
    output logic                                o_pe_en,
    output logic                                o_psum_out_en,
    output logic                                o_ofmap_valid,
    output logic                                o_busy,
    output logic                                o_done
);

    localparam int FLUSH_LEN = sa_flush_len(S_WIDTH, S_HEIGHT);
    localparam int PHASE_W   = $clog2(S_WIDTH + S_HEIGHT);
    localparam logic [PHASE_W-1:0] FLUSH_LAST = PHASE_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
    localparam logic [PHASE_W-1:0] DRAIN_LAST = PHASE_W'(S_WIDTH - 1);

    sa_ctrl_state_t     state_q, state_d;
    logic [K_WIDTH-1:0] k_len_q, k_len_d;
    logic [1:0]         mode_q, mode_d;
    logic [K_WIDTH-1:0] step_q, step_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               pe_en;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        k_len_d = k_len_q;
        mode_d  = mode_q;
        step_d  = step_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CLEAR;
                    k_len_d = i_k_len;
                    mode_d  = i_mode;
                end
            end
            ST_CLEAR: state_d = (k_len_q == '0) ? ST_DONE : ST_FEED;
            ST_FEED: begin
                if (i_in_valid) begin
                    step_d = step_q + 1'b1;
                    // NOTE: compare the incremented count so the K-th handshake itself leaves FEED.
                    if (step_d == k_len_q) begin
                        state_d = (FLUSH_LEN == 0) ? ST_DRAIN : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == FLUSH_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) begin
            step_d  = '0;
            phase_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            k_len_q <= '0;
            mode_q  <= SA_MODE_MAC;
            step_q  <= '0;
            phase_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            k_len_q <= k_len_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            phase_q <= phase_d;
        end
    end

    assign pe_en         = ((state_q == ST_FEED) && i_in_valid) || (state_q == ST_FLUSH);
    assign o_pe_en       = pe_en;
    assign o_in_ready    = (state_q == ST_FEED);
    assign o_reg_clear   = (state_q == ST_CLEAR);
    assign o_psum_out_en = (state_q == ST_DRAIN);
    assign o_ofmap_valid = (state_q == ST_DRAIN);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_mode        = mode_q;

`ifdef SA_CTRL_SKEW_EN
    logic [S_HEIGHT-1:0][DATA_WIDTH-1:0] ifmap_in;
    logic [S_WIDTH-1:0][DATA_WIDTH-1:0]  weight_in;

    // Outside FEED zeros enter the chain, pushing the tail of the tile through.
    assign ifmap_in  = (state_q == ST_FEED) ? i_ifmap  : '0;
    assign weight_in = (state_q == ST_FEED) ? i_weight : '0;

    sa_skew_buffer #(.LANES(S_HEIGHT), .WIDTH(DATA_WIDTH)) u_row_skew (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (pe_en),
        .i_data (ifmap_in),
        .o_data (o_ifmap)
    );

    sa_skew_buffer #(.LANES(S_WIDTH), .WIDTH(DATA_WIDTH)) u_col_skew (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (pe_en),
        .i_data (weight_in),
        .o_data (o_weight)
    );
`else
    assign o_ifmap  = i_ifmap;
    assign o_weight = i_weight;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: per-cycle strobe timeline model,
// plus a behavioural output-stationary array fed by the DUT to check the skew.
module tb_systolic_array_ctrl;

    localparam int DW   = 8;
    localparam int W    = 2;
    localparam int H    = 2;
    localparam int KW   = 16;
    localparam int MAXK = 16;
    localparam int FL   = W + H - 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst, i_start, i_in_valid;
    logic [KW-1:0]        i_k_len;
    logic [1:0]           i_mode;
    logic [H-1:0][DW-1:0] i_ifmap, o_ifmap;
    logic [W-1:0][DW-1:0] i_weight, o_weight;
    logic [1:0]           o_mode;
    logic                 o_in_ready, o_reg_clear, o_pe_en, o_psum_out_en;
    logic                 o_ofmap_valid, o_busy, o_done;

    systolic_array_ctrl #(
        .DATA_WIDTH (DW),
        .S_WIDTH    (W),
        .S_HEIGHT   (H),
        .K_WIDTH    (KW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_k_len       (i_k_len),
        .i_mode        (i_mode),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_ifmap       (i_ifmap),
        .i_weight      (i_weight),
        .o_ifmap       (o_ifmap),
        .o_weight      (o_weight),
        .o_mode        (o_mode),
        .o_reg_clear   (o_reg_clear),
        .o_pe_en       (o_pe_en),
        .o_psum_out_en (o_psum_out_en),
        .o_ofmap_valid (o_ofmap_valid),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic start, valid, clear, pe_en, psum, ovalid, ready, busy, done;
    } cyc_t;

    cyc_t tl[$];
    int   ifm[MAXK][H];
    int   wgt[MAXK][W];
    int   acc[H][W];
    int   a_r[H][W];
    int   b_r[H][W];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one tile, index 0 = start cycle.
    task automatic build_tl(input int k, input int stall_pct, input int stall_at,
                            input int poke_at, output int done_at);
        cyc_t c;
        int   f = 0;
        int   n = 0;
        tl.delete();
        c = '0; c.start = 1'b1; tl.push_back(c);
        c = '0; c.clear = 1'b1; c.busy = 1'b1; tl.push_back(c);
        if (k > 0) begin
            while (n < k) begin
                c = '0; c.ready = 1'b1; c.busy = 1'b1;
                if (f == stall_at) c.valid = 1'b0;
                else if (f > 4 * k + 8) c.valid = 1'b1;
                else c.valid = ($urandom_range(99) >= stall_pct);
                c.pe_en = c.valid;
                c.start = (f == poke_at);
                if (c.valid) n++;
                tl.push_back(c);
                f++;
            end
            repeat (FL) begin c = '0; c.pe_en = 1'b1; c.busy = 1'b1; tl.push_back(c); end
            repeat (W) begin c = '0; c.psum = 1'b1; c.ovalid = 1'b1; c.busy = 1'b1; tl.push_back(c); end
        end
        c = '0; c.done = 1'b1; c.busy = 1'b1; done_at = tl.size(); tl.push_back(c);
        repeat (3) begin c = '0; tl.push_back(c); end
    endtask

    // Which reduction step a lane should present on the en_idx-th enabled cycle.
    function automatic int step_for(input int en_idx, input int lane);
`ifdef SA_CTRL_SKEW_EN
        return en_idx + 0 * lane;
`else
        return en_idx - lane;
`endif
    endfunction

    task automatic drive_data(input int k, input int en_idx);
        int s;
        i_ifmap  = '0;
        i_weight = '0;
        for (int r = 0; r < H; r++) begin
            s = step_for(en_idx, r);
            if (s >= 0 && s < k) i_ifmap[r] = DW'(ifm[s][r]);
        end
        for (int c = 0; c < W; c++) begin
            s = step_for(en_idx, c);
            if (s >= 0 && s < k) i_weight[c] = DW'(wgt[s][c]);
        end
    endtask

    task automatic array_step();
        int a, b;
        if (o_reg_clear) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    acc[r][c] = 0; a_r[r][c] = 0; b_r[r][c] = 0;
                end
        end else if (o_pe_en) begin
            for (int r = H - 1; r >= 0; r--)
                for (int c = W - 1; c >= 0; c--) begin
                    if (c == 0) a = int'(o_ifmap[r]); else a = a_r[r][c-1];
                    if (r == 0) b = int'(o_weight[c]); else b = b_r[r-1][c];
                    acc[r][c] += a * b;
                    a_r[r][c] = a;
                    b_r[r][c] = b;
                end
        end
    endtask

    task automatic check_results(input int k);
        int e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                e = 0;
                for (int s = 0; s < k; s++) e += ifm[s][r] * wgt[s][c];
                check($sformatf("result[%0d][%0d] k=%0d", r, c, k), 64'(acc[r][c]), 64'(e));
            end
    endtask

    task automatic fill_const();
        for (int s = 0; s < MAXK; s++) begin
            ifm[s][0] = 1; ifm[s][1] = 2;
            wgt[s][0] = 3; wgt[s][1] = 4;
        end
    endtask

    task automatic fill_random();
        for (int s = 0; s < MAXK; s++) begin
            for (int r = 0; r < H; r++) ifm[s][r] = int'($urandom_range(255));
            for (int c = 0; c < W; c++) wgt[s][c] = int'($urandom_range(255));
        end
    endtask

    task automatic run_tile(input int k, input logic [1:0] mode, input int stall_pct,
                            input int stall_at, input int poke_at, input int rst_at);
        int   done_at;
        int   en_idx  = 0;
        int   n_done  = 0;
        int   seen_at = -1;
        cyc_t c;
        build_tl(k, stall_pct, stall_at, poke_at, done_at);
        i_k_len = KW'(k);
        i_mode  = mode;
        for (int t = 0; t < tl.size(); t++) begin
            c = tl[t];
            @(negedge i_clk);
            i_start    = c.start;
            i_in_valid = c.valid;
            i_rst      = (t == rst_at);
            drive_data(k, en_idx);
            #1;
            check($sformatf("strobes k=%0d t=%0d", k, t),
                  64'({o_reg_clear, o_pe_en, o_psum_out_en, o_ofmap_valid, o_in_ready, o_busy, o_done}),
                  64'({c.clear, c.pe_en, c.psum, c.ovalid, c.ready, c.busy, c.done}));
            if (c.busy) check($sformatf("mode t=%0d", t), 64'(o_mode), 64'(mode));
`ifndef SA_CTRL_SKEW_EN
            check($sformatf("ifmap_pass t=%0d", t), 64'(o_ifmap), 64'(i_ifmap));
            check($sformatf("weight_pass t=%0d", t), 64'(o_weight), 64'(i_weight));
`endif
            if (o_done) begin
                n_done++;
                seen_at = t;
            end
            array_step();
            if (c.done) check_results(k);
            if (c.pe_en) en_idx++;
            if (t == rst_at) break;
        end
        if (rst_at >= 0) begin
            @(negedge i_clk);
            i_rst = 1'b0; i_start = 1'b0; i_in_valid = 1'b0;
            i_ifmap = '0; i_weight = '0;
            #1;
            check("rst_strobes",
                  64'({o_reg_clear, o_pe_en, o_psum_out_en, o_ofmap_valid, o_in_ready, o_busy, o_done}), 64'd0);
            check("rst_mode", 64'(o_mode), 64'd0);
            check("rst_ifmap", 64'(o_ifmap), 64'd0);
            check("rst_weight", 64'(o_weight), 64'd0);
            check("rst_no_done", 64'(n_done), 64'd0);
        end else begin
            check($sformatf("done_count k=%0d", k), 64'(n_done), 64'd1);
            check($sformatf("done_cycle k=%0d", k), 64'(seen_at), 64'(done_at));
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_in_valid = 1'b0;
        i_k_len = '0; i_mode = '0; i_ifmap = '0; i_weight = '0;
        repeat (3) @(negedge i_clk);
        #1;
        check("reset_strobes",
              64'({o_reg_clear, o_pe_en, o_psum_out_en, o_ofmap_valid, o_in_ready, o_busy, o_done}), 64'd0);
        check("reset_mode", 64'(o_mode), 64'd0);
        check("reset_ifmap", 64'(o_ifmap), 64'd0);
        check("reset_weight", 64'(o_weight), 64'd0);

        fill_const();
        run_tile(3, 2'd0, 0, -1, -1, -1);   // done at cycle 9
        run_tile(3, 2'd1, 0, 1, -1, -1);    // stall on second FEED cycle, done at 10
        run_tile(0, 2'd2, 0, -1, -1, -1);   // CLEAR then DONE
        run_tile(3, 2'd3, 0, -1, 1, -1);    // start pulsed during FEED is ignored
        run_tile(3, 2'd3, 0, -1, -1, 7);    // reset in first DRAIN cycle
        run_tile(3, 2'd1, 0, -1, -1, -1);

        // Start and reset together: reset wins.
        @(negedge i_clk);
        i_rst = 1'b1; i_start = 1'b1; i_k_len = KW'(2);
        @(negedge i_clk);
        i_rst = 1'b0; i_start = 1'b0;
        #1;
        check("start_vs_rst_busy", 64'(o_busy), 64'd0);

        for (int n = 0; n < 20; n++) begin
            fill_random();
            run_tile(int'($urandom_range(8)), 2'($urandom_range(3)), 30, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
